// File: rtl/seg_mux_scheduler_if.sv
// Digit/segment bus between the data source and the two-digit display scheduler.
// SEG_DIM_EN adds the 3-bit brightness input.
interface seg_mux_scheduler_if;
    logic       en;
    logic [3:0] s1;
    logic [3:0] s2;
`ifdef SEG_DIM_EN
    logic [2:0] bright;
`endif
    logic [6:0] seg;
    logic       anode1_en;
    logic       anode2_en;
    logic       frame_done;

`ifdef SEG_DIM_EN
    modport master (output en, s1, s2, bright, input seg, anode1_en, anode2_en, frame_done);
    modport slave  (input en, s1, s2, bright, output seg, anode1_en, anode2_en, frame_done);
`else
    modport master (output en, s1, s2, input seg, anode1_en, anode2_en, frame_done);
    modport slave  (input en, s1, s2, output seg, anode1_en, anode2_en, frame_done);
`endif
endinterface

// File: rtl/seg_mux_scheduler.sv
// Two-digit time-multiplexed 7-segment driver with dead time between digits.
// Optional SEG_DIM_EN: per-digit brightness via shortened anode on-time.
module seg_mux_scheduler #(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                clk,
    input  logic                reset_n,
    seg_mux_scheduler_if.slave  bus
);
    localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    BLANK_SEG  = 7'h7F;

    typedef enum logic [1:0] {SHOW1, BLANK1, SHOW2, BLANK2} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          phase_last;
    logic [3:0]    d1_q;
    logic [3:0]    d2_q;
    logic          armed;
    logic [6:0]    seg_q;
    logic          an1_q;
    logic          an2_q;
    logic          fd_q;
    logic          lit1_run;
    logic          lit2_run;
    logic          lit_entry;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h67;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h58;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return ~g;
    endfunction

    assign cnt_inc    = cnt + 1'b1;
    assign phase_last = (state == SHOW1 || state == SHOW2) ? (cnt == DWELL_LAST)
                                                           : (cnt == BLANK_LAST);

`ifdef SEG_DIM_EN
    logic [2:0] b1_q;
    logic [2:0] b2_q;

    // Lit portion of a SHOW phase, in clocks, for a given brightness code.
    function automatic int on_len(input logic [2:0] b);
        return ((int'(b) + 1) * DWELL_CYCLES) >> 3;
    endfunction

    assign lit1_run  = int'(cnt_inc) < on_len(b1_q);
    assign lit2_run  = int'(cnt_inc) < on_len(b2_q);
    assign lit_entry = on_len(bus.bright) > 0;
`else
    assign lit1_run  = 1'b1;
    assign lit2_run  = 1'b1;
    assign lit_entry = 1'b1;
`endif

    // Outputs are computed for the state being entered so anode and seg switch with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK2;
            cnt   <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
            armed <= 1'b0;
            seg_q <= BLANK_SEG;
            an1_q <= 1'b1;
            an2_q <= 1'b1;
            fd_q  <= 1'b0;
`ifdef SEG_DIM_EN
            b1_q  <= '0;
            b2_q  <= '0;
`endif
        end else if (!bus.en) begin
            state <= BLANK2;
            cnt   <= '0;
            armed <= 1'b0;
            seg_q <= BLANK_SEG;
            an1_q <= 1'b1;
            an2_q <= 1'b1;
            fd_q  <= 1'b0;
        end else if (!phase_last) begin
            cnt  <= cnt_inc;
            fd_q <= 1'b0;
            unique case (state)
                SHOW1: begin
                    seg_q <= lit1_run ? decode(d1_q) : BLANK_SEG;
                    an1_q <= !lit1_run;
                    an2_q <= 1'b1;
                end
                SHOW2: begin
                    seg_q <= lit2_run ? decode(d2_q) : BLANK_SEG;
                    an1_q <= 1'b1;
                    an2_q <= !lit2_run;
                end
                default: begin
                    seg_q <= BLANK_SEG;
                    an1_q <= 1'b1;
                    an2_q <= 1'b1;
                end
            endcase
        end else begin
            cnt  <= '0;
            fd_q <= 1'b0;
            unique case (state)
                BLANK2: begin
                    state <= SHOW1;
                    d1_q  <= bus.s1;
                    seg_q <= lit_entry ? decode(bus.s1) : BLANK_SEG;
                    an1_q <= !lit_entry;
                    an2_q <= 1'b1;
                    // First entry after reset or enable starts a frame but does not end one.
                    fd_q  <= armed;
                    armed <= 1'b1;
`ifdef SEG_DIM_EN
                    b1_q  <= bus.bright;
`endif
                end
                BLANK1: begin
                    state <= SHOW2;
                    d2_q  <= bus.s2;
                    seg_q <= lit_entry ? decode(bus.s2) : BLANK_SEG;
                    an1_q <= 1'b1;
                    an2_q <= !lit_entry;
`ifdef SEG_DIM_EN
                    b2_q  <= bus.bright;
`endif
                end
                SHOW1: begin
                    state <= BLANK1;
                    seg_q <= BLANK_SEG;
                    an1_q <= 1'b1;
                    an2_q <= 1'b1;
                end
                SHOW2: begin
                    state <= BLANK2;
                    seg_q <= BLANK_SEG;
                    an1_q <= 1'b1;
                    an2_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.seg        = seg_q;
    assign bus.anode1_en  = an1_q;
    assign bus.anode2_en  = an2_q;
    assign bus.frame_done = fd_q;
endmodule
